aurora_tx_ingress_fifo: RTL and testbench

//  User-side AXI-Stream ingress buffer directly upstream of the Aurora TX top (data controller input).

---
 rtl/aurora_tx_ingress_fifo.sv | 218 +++++++++++++++++++++
 tb/tb_aurora_tx_ingress_fifo.sv | 333 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/aurora_tx_ingress_fifo.sv
`default_nettype none
// ============================================================================
// Module      : aurora_tx_ingress_fifo
// Description : AXI-Stream ingress buffer ahead of the Aurora TX data
//               controller. Frames are accepted with tready backpressure into
//               a DEPTH-entry FIFO of {last, data} and replayed on a
//               ready-less axi_valid/axi_last/axi_data port once the link is
//               up. Frames longer than the FIFO are cut through when it fills.
//               A link loss mid-frame flushes the rest of that frame and
//               pulses frame_dropped.
//               Optional macro AURORA_TX_FIFO_STATS_EN adds frames_sent and
//               frames_dropped_cnt counters.
// Revision    : 1.0 - initial release
// ============================================================================
module aurora_tx_ingress_fifo #(
    parameter int DATA_W = 32,
    parameter int DEPTH  = 16
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   s_axis_tvalid,
    output logic                   s_axis_tready,
    input  logic                   s_axis_tlast,
    input  logic [DATA_W-1:0]      s_axis_tdata,
    input  logic                   link_ready,
    input  logic                   pause,
    output logic                   axi_valid,
    output logic                   axi_last,
    output logic [DATA_W-1:0]      axi_data,
    output logic [$clog2(DEPTH):0] level,
`ifdef AURORA_TX_FIFO_STATS_EN
    output logic [15:0]            frames_sent,
    output logic [15:0]            frames_dropped_cnt,
`endif
    output logic                   frame_dropped
);

    localparam int                  c_ADDR_W   = $clog2(DEPTH);
    localparam logic [c_ADDR_W:0]   c_CNT_FULL = (c_ADDR_W + 1)'(DEPTH);
    localparam logic [c_ADDR_W:0]   c_CNT_ONE  = (c_ADDR_W + 1)'(1);
    localparam logic [c_ADDR_W-1:0] c_PTR_ONE  = c_ADDR_W'(1);

    localparam logic [1:0] c_ST_IDLE  = 2'd0;
    localparam logic [1:0] c_ST_SEND  = 2'd1;
    localparam logic [1:0] c_ST_FLUSH = 2'd2;

    logic [DATA_W:0]     r_mem [DEPTH];
    logic [c_ADDR_W-1:0] r_wr_ptr;
    logic [c_ADDR_W-1:0] r_rd_ptr;
    logic [c_ADDR_W:0]   r_count;
    logic [c_ADDR_W:0]   r_frames;
    logic [1:0]          r_state;
    logic                r_axi_valid;
    logic                r_axi_last;
    logic [DATA_W-1:0]   r_axi_data;
    logic                r_frame_dropped;

    logic                w_full;
    logic                w_empty;
    logic                w_push_req;
    logic [DATA_W:0]     w_head;
    logic                w_head_last;
    logic                w_start;
    logic                w_continue;
    logic                w_write;
    logic                w_pop;
    logic                w_out_valid;
    logic                w_drop;
    logic [1:0]          w_next_state;
    logic                w_frame_inc;
    logic                w_frame_dec;

    assign w_full        = (r_count == c_CNT_FULL);
    assign w_empty       = (r_count == '0);
    assign w_push_req    = s_axis_tvalid && !w_full;
    assign w_head        = r_mem[r_rd_ptr];
    assign w_head_last   = w_head[DATA_W];
    // A stored complete frame, or a full FIFO (frame longer than DEPTH), may start
    assign w_start       = link_ready && !pause && ((r_frames != '0) || w_full);
    // Same test after the current frame's last word leaves: another complete frame must remain
    assign w_continue    = link_ready && !pause && ((r_frames > c_CNT_ONE) || w_full);
    assign w_frame_inc   = w_write && s_axis_tlast;
    assign w_frame_dec   = w_pop && w_head_last;

    assign s_axis_tready = !w_full;
    assign level         = r_count;
    assign axi_valid     = r_axi_valid;
    assign axi_last      = r_axi_last;
    assign axi_data      = r_axi_data;
    assign frame_dropped = r_frame_dropped;

    // Next-state, pop/write control and output-word selection
    always_comb begin
        w_next_state = r_state;
        w_write      = w_push_req;
        w_pop        = 1'b0;
        w_out_valid  = 1'b0;
        w_drop       = 1'b0;
        case (r_state)
            c_ST_IDLE: begin
                if (w_start) begin
                    w_next_state = c_ST_SEND;
                end
            end
            c_ST_SEND: begin
                // A last word at the head still goes out even if the link just fell
                if (!w_empty && (link_ready || w_head_last)) begin
                    w_pop       = 1'b1;
                    w_out_valid = 1'b1;
                    if (w_head_last) begin
                        w_next_state = w_continue ? c_ST_SEND : c_ST_IDLE;
                    end
                end else if (!link_ready) begin
                    w_next_state = c_ST_FLUSH;
                end
            end
            c_ST_FLUSH: begin
                if (!w_empty) begin
                    w_pop = 1'b1;
                    if (w_head_last) begin
                        w_drop       = 1'b1;
                        w_next_state = c_ST_IDLE;
                    end
                end else if (w_push_req) begin
                    // Tail of a cut-through frame still arriving: swallow it unstored
                    w_write = 1'b0;
                    if (s_axis_tlast) begin
                        w_drop       = 1'b1;
                        w_next_state = c_ST_IDLE;
                    end
                end
            end
            default: begin
                w_next_state = c_ST_IDLE;
            end
        endcase
    end

    // FIFO storage; contents need no reset since the pointers define validity
    always_ff @(posedge clk) begin
        if (w_write) begin
            r_mem[r_wr_ptr] <= {s_axis_tlast, s_axis_tdata};
        end
    end

    // Pointers, occupancy and stored-frame count
    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
            r_frames <= '0;
        end else begin
            if (w_write) begin
                r_wr_ptr <= r_wr_ptr + c_PTR_ONE;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + c_PTR_ONE;
            end
            case ({w_write, w_pop})
                2'b10:   r_count <= r_count + c_CNT_ONE;
                2'b01:   r_count <= r_count - c_CNT_ONE;
                default: r_count <= r_count;
            endcase
            case ({w_frame_inc, w_frame_dec})
                2'b10:   r_frames <= r_frames + c_CNT_ONE;
                2'b01:   r_frames <= r_frames - c_CNT_ONE;
                default: r_frames <= r_frames;
            endcase
        end
    end

    // State register and registered output port
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state         <= c_ST_IDLE;
            r_axi_valid     <= 1'b0;
            r_axi_last      <= 1'b0;
            r_axi_data      <= '0;
            r_frame_dropped <= 1'b0;
        end else begin
            r_state         <= w_next_state;
            r_axi_valid     <= w_out_valid;
            r_frame_dropped <= w_drop;
            if (w_out_valid) begin
                r_axi_last <= w_head_last;
                r_axi_data <= w_head[DATA_W-1:0];
            end else begin
                r_axi_last <= 1'b0;
            end
        end
    end

`ifdef AURORA_TX_FIFO_STATS_EN
    logic [15:0] r_frames_sent;
    logic [15:0] r_frames_dropped_cnt;

    assign frames_sent        = r_frames_sent;
    assign frames_dropped_cnt = r_frames_dropped_cnt;

    // Wrapping counters of frames delivered and frames aborted
    always_ff @(posedge clk) begin
        if (rst) begin
            r_frames_sent        <= '0;
            r_frames_dropped_cnt <= '0;
        end else begin
            if (w_out_valid && w_head_last) begin
                r_frames_sent <= r_frames_sent + 16'd1;
            end
            if (w_drop) begin
                r_frames_dropped_cnt <= r_frames_dropped_cnt + 16'd1;
            end
        end
    end
`endif

endmodule
`default_nettype wire

// File: tb/tb_aurora_tx_ingress_fifo.sv
`default_nettype none
// ============================================================================
// Module      : tb_aurora_tx_ingress_fifo
// Description : Self-checking bench for aurora_tx_ingress_fifo. A queue-based
//               reference model tracks the buffered words and the frame
//               release rules; directed scenarios plus a random phase are
//               compared against it every cycle.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_aurora_tx_ingress_fifo;

    localparam int DATA_W = 32;
    localparam int DEPTH  = 16;
    localparam int LW     = $clog2(DEPTH) + 1;

    logic              clk = 1'b0;
    logic              rst;
    logic              s_axis_tvalid;
    logic              s_axis_tready;
    logic              s_axis_tlast;
    logic [DATA_W-1:0] s_axis_tdata;
    logic              link_ready;
    logic              pause;
    logic              axi_valid;
    logic              axi_last;
    logic [DATA_W-1:0] axi_data;
    logic [LW-1:0]     level;
    logic              frame_dropped;
`ifdef AURORA_TX_FIFO_STATS_EN
    logic [15:0]       frames_sent;
    logic [15:0]       frames_dropped_cnt;
`endif

    aurora_tx_ingress_fifo #(.DATA_W(DATA_W), .DEPTH(DEPTH)) dut (
        .clk               (clk),
        .rst               (rst),
        .s_axis_tvalid     (s_axis_tvalid),
        .s_axis_tready     (s_axis_tready),
        .s_axis_tlast      (s_axis_tlast),
        .s_axis_tdata      (s_axis_tdata),
        .link_ready        (link_ready),
        .pause             (pause),
        .axi_valid         (axi_valid),
        .axi_last          (axi_last),
        .axi_data          (axi_data),
        .level             (level),
`ifdef AURORA_TX_FIFO_STATS_EN
        .frames_sent       (frames_sent),
        .frames_dropped_cnt(frames_dropped_cnt),
`endif
        .frame_dropped     (frame_dropped)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Reference model: buffered words as a queue, mode 0=idle 1=sending 2=flushing
    logic [DATA_W:0]   m_q[$];
    int                m_mode = 0;
    logic              m_valid = 1'b0;
    logic              m_last = 1'b0;
    logic [DATA_W-1:0] m_data = '0;
    logic              m_drop = 1'b0;
    int                m_sent = 0;
    int                m_dropped = 0;

    function automatic int m_frames();
        int n = 0;
        foreach (m_q[i]) if (m_q[i][DATA_W]) n++;
        return n;
    endfunction

    // Model advances on each rising edge using the inputs held across it
    always @(posedge clk) begin : p_model
        bit              full, push, start, cont;
        logic [DATA_W:0] item;
        full    = (m_q.size() == DEPTH);
        push    = s_axis_tvalid && !full;
        m_valid = 1'b0;
        m_last  = 1'b0;
        m_drop  = 1'b0;
        if (rst) begin
            m_q.delete();
            m_mode    = 0;
            m_data    = '0;
            m_sent    = 0;
            m_dropped = 0;
        end else begin
            start = link_ready && !pause && (m_frames() > 0 || full);
            cont  = link_ready && !pause && (m_frames() > 1 || full);
            if (m_mode == 0) begin
                if (start) m_mode = 1;
            end else if (m_mode == 1) begin
                if (m_q.size() > 0 && (link_ready || m_q[0][DATA_W])) begin
                    item    = m_q.pop_front();
                    m_valid = 1'b1;
                    m_last  = item[DATA_W];
                    m_data  = item[DATA_W-1:0];
                    if (item[DATA_W]) begin
                        m_sent++;
                        m_mode = cont ? 1 : 0;
                    end
                end else if (!link_ready) begin
                    m_mode = 2;
                end
            end else begin
                if (m_q.size() > 0) begin
                    item = m_q.pop_front();
                    if (item[DATA_W]) begin
                        m_drop = 1'b1;
                        m_dropped++;
                        m_mode = 0;
                    end
                end else if (push) begin
                    push = 1'b0;
                    if (s_axis_tlast) begin
                        m_drop = 1'b1;
                        m_dropped++;
                        m_mode = 0;
                    end
                end
            end
            if (push) m_q.push_back({s_axis_tlast, s_axis_tdata});
        end
    end

    // Observation tallies for the directed scenarios
    int                obs_n, obs_lasts, obs_drops, run, maxrun;
    logic [DATA_W-1:0] obs_d[$];
    logic              obs_l[$];
    bit                hs;
    bit                saw_full;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_model();
        chk("valid", 64'(axi_valid), 64'(m_valid));
        chk("last", 64'(axi_last), 64'(m_last));
        if (m_valid) chk("data", 64'(axi_data), 64'(m_data));
        chk("level", 64'(level), 64'(m_q.size()));
        chk("tready", 64'(s_axis_tready), 64'(m_q.size() != DEPTH));
        chk("frame_dropped", 64'(frame_dropped), 64'(m_drop));
`ifdef AURORA_TX_FIFO_STATS_EN
        chk("frames_sent", 64'(frames_sent), 64'(16'(m_sent)));
        chk("frames_dropped_cnt", 64'(frames_dropped_cnt), 64'(16'(m_dropped)));
`endif
    endtask

    task automatic clear_obs();
        obs_n = 0; obs_lasts = 0; obs_drops = 0; run = 0; maxrun = 0;
        obs_d.delete(); obs_l.delete(); saw_full = 0;
    endtask

    // One clock: note the handshake, cross the edge, compare at the falling edge
    task automatic tick();
        hs = s_axis_tvalid && s_axis_tready;
        @(negedge clk);
        chk_model();
        if (axi_valid) begin
            obs_n++;
            obs_d.push_back(axi_data);
            obs_l.push_back(axi_last);
            if (axi_last) obs_lasts++;
            run++;
            if (run > maxrun) maxrun = run;
        end else begin
            run = 0;
        end
        if (frame_dropped) obs_drops++;
        if (level == LW'(DEPTH) && !s_axis_tready) saw_full = 1;
    endtask

    task automatic idle(input int n);
        s_axis_tvalid = 1'b0;
        s_axis_tlast  = 1'b0;
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic push(input logic [DATA_W-1:0] d, input logic l);
        int k = 0;
        s_axis_tvalid = 1'b1;
        s_axis_tdata  = d;
        s_axis_tlast  = l;
        do begin
            tick();
            k++;
        end while (!hs && k < 50);
        if (!hs) begin
            checks++;
            errors++;
            $error("FAIL push_timeout observed=no_handshake expected=handshake");
        end
        s_axis_tvalid = 1'b0;
        s_axis_tlast  = 1'b0;
    endtask

    initial begin
        rst = 1'b1; s_axis_tvalid = 1'b0; s_axis_tlast = 1'b0; s_axis_tdata = '0;
        link_ready = 1'b1; pause = 1'b0;
        clear_obs();
        tick();
        tick();
        rst = 1'b0;
        chk("reset_valid", 64'(axi_valid), 64'd0);
        chk("reset_level", 64'(level), 64'd0);
        chk("reset_tready", 64'(s_axis_tready), 64'd1);
        chk("reset_dropped", 64'(frame_dropped), 64'd0);

        // Single-word frame latency
        push(32'hA5A50001, 1'b1);
        chk("t1_n", 64'(axi_valid), 64'd0);
        tick();
        chk("t1_n1", 64'(axi_valid), 64'd0);
        tick();
        chk("t1_n2_valid", 64'(axi_valid), 64'd1);
        chk("t1_n2_last", 64'(axi_last), 64'd1);
        chk("t1_n2_data", 64'(axi_data), 64'hA5A50001);
        tick();
        chk("t1_n3_valid", 64'(axi_valid), 64'd0);

        // Incomplete frame is held; completing it releases 4 consecutive words
        clear_obs();
        for (int i = 0; i < 3; i++) push(32'h100 + i, 1'b0);
        idle(4);
        chk("t2_held", 64'(obs_n), 64'd0);
        push(32'h103, 1'b1);
        idle(8);
        chk("t2_count", 64'(obs_n), 64'd4);
        chk("t2_run", 64'(maxrun), 64'd4);
        chk("t2_lasts", 64'(obs_lasts), 64'd1);
        for (int i = 0; i < 4 && i < obs_d.size(); i++) chk("t2_order", 64'(obs_d[i]), 64'(32'h100 + i));
        if (obs_l.size() == 4) chk("t2_last_pos", 64'(obs_l[3]), 64'd1);

        // 20-word frame through a 16-deep FIFO: forced cut-through
        clear_obs();
        begin
            int idx = 0;
            int guard = 0;
            while (idx < 20 && guard < 100) begin
                s_axis_tvalid = 1'b1;
                s_axis_tdata  = 32'h200 + idx;
                s_axis_tlast  = (idx == 19);
                tick();
                if (hs) idx++;
                guard++;
            end
            chk("t3_all_pushed", 64'(idx), 64'd20);
        end
        idle(25);
        chk("t3_saw_full", 64'(saw_full), 64'd1);
        chk("t3_count", 64'(obs_n), 64'd20);
        chk("t3_lasts", 64'(obs_lasts), 64'd1);
        for (int i = 0; i < 20 && i < obs_d.size(); i++) chk("t3_order", 64'(obs_d[i]), 64'(32'h200 + i));
        if (obs_l.size() == 20) chk("t3_last_pos", 64'(obs_l[19]), 64'd1);

        // Link loss after 3 of 8 words: rest flushed, one drop pulse
        clear_obs();
        for (int i = 0; i < 8; i++) push(32'h300 + i, i == 7);
        for (int i = 0; i < 30 && obs_n < 3; i++) tick();
        chk("t4_three_out", 64'(obs_n), 64'd3);
        link_ready = 1'b0;
        tick();
        chk("t4_valid_off", 64'(axi_valid), 64'd0);
        idle(10);
        chk("t4_out_total", 64'(obs_n), 64'd3);
        chk("t4_drops", 64'(obs_drops), 64'd1);
        chk("t4_level", 64'(level), 64'd0);

        // Two frames buffered while link is down, then sent back-to-back
        clear_obs();
        for (int i = 0; i < 4; i++) push(32'h400 + i, (i % 2) == 1);
        idle(3);
        chk("t5_level", 64'(level), 64'd4);
        chk("t5_held", 64'(obs_n), 64'd0);
        link_ready = 1'b1;
        idle(8);
        chk("t5_count", 64'(obs_n), 64'd4);
        chk("t5_run", 64'(maxrun), 64'd4);
        chk("t5_lasts", 64'(obs_lasts), 64'd2);
        if (obs_l.size() == 4) begin
            chk("t5_last1", 64'(obs_l[1]), 64'd1);
            chk("t5_last3", 64'(obs_l[3]), 64'd1);
        end
`ifdef AURORA_TX_FIFO_STATS_EN
        chk("stats_sent", 64'(frames_sent), 64'd5);
        chk("stats_dropped", 64'(frames_dropped_cnt), 64'd1);
`endif

        // Reset mid-frame, then normal single-word latency
        push(32'h500, 1'b0);
        push(32'h501, 1'b0);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("t6_level", 64'(level), 64'd0);
        chk("t6_valid", 64'(axi_valid), 64'd0);
        chk("t6_tready", 64'(s_axis_tready), 64'd1);
        clear_obs();
        push(32'hA5A50002, 1'b1);
        tick();
        chk("t6_n1", 64'(axi_valid), 64'd0);
        tick();
        chk("t6_n2_valid", 64'(axi_valid), 64'd1);
        chk("t6_n2_data", 64'(axi_data), 64'hA5A50002);
        idle(4);
        chk("t6_count", 64'(obs_n), 64'd1);

        // Random traffic, link flaps and pauses against the model
        for (int c = 0; c < 600; c++) begin
            s_axis_tvalid = ($urandom_range(0, 1) == 1);
            s_axis_tlast  = ($urandom_range(0, 3) == 0);
            s_axis_tdata  = $urandom();
            link_ready    = ($urandom_range(0, 19) != 0);
            pause         = ($urandom_range(0, 9) == 0);
            tick();
        end
        link_ready = 1'b1;
        pause      = 1'b0;
        idle(40);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
